// File: rtl/ppg_mult_pkg.sv
// Shared types and sizes for the sequential shift-add multiplier.
// Holds the PPG row width, product width and controller state encoding.
package ppg_mult_pkg;

  localparam int PPG_W  = 16;
  localparam int PROD_W = 32;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ppg_state_t;

  typedef logic [PPG_W-1:0]  operand_t;
  typedef logic [PROD_W-1:0] product_t;

endpackage

// File: rtl/PPG.sv
// Single partial-product generator row.
// Every multiplicand bit is gated by one multiplier bit.
module PPG
  import ppg_mult_pkg::*;
(
  output logic [PPG_W-1:0] res,
  input  logic [PPG_W-1:0] a,
  input  logic             b
);

  // AND-gate row: res is a when b is set, else zero
  always_comb begin
    res = a & {PPG_W{b}};
  end

endmodule

// File: rtl/ppg_seq_mult_ctrl.sv
// Sequential shift-add multiplier: one PPG row reused for all 16 bits.
// Build option PPG_SEQ_ZERO_SKIP_EN stops early once remaining b bits are 0.
module ppg_seq_mult_ctrl
  import ppg_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  if (WIDTH != PPG_W || CNT_W != IDX_W) begin : g_bad_cfg
    $error("ppg_seq_mult_ctrl: WIDTH must be 16 and CNT_W must be 4");
  end

  ppg_state_t           state;
  operand_t             a_r;
  operand_t             b_r;
  product_t             acc;
  logic [CNT_W-1:0]     idx;
  operand_t             pp;
  product_t             addend;
  product_t             acc_sum;
  logic                 last;

  PPG u_ppg (
    .res (pp),
    .a   (a_r),
    .b   (b_r[idx])
  );

`ifdef PPG_SEQ_ZERO_SKIP_EN
  operand_t hi;

  // finish as soon as no multiplier bit above idx is set
  always_comb begin
    hi   = b_r >> idx;
    last = (hi[PPG_W-1:1] == '0);
  end
`else
  // always walk through all multiplier bits
  always_comb begin
    last = (idx == CNT_W'(WIDTH-1));
  end
`endif

  // shifted partial product folded into the running sum
  always_comb begin
    addend  = product_t'(pp) << idx;
    acc_sum = acc + addend;
  end

  // control FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      busy      <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_sum;
          idx <= idx + CNT_W'(1);
          if (last) begin
            out_p     <= acc_sum;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppg_seq_mult_ctrl.sv
// Scoreboard bench for ppg_seq_mult_ctrl.
// Driver pushes expected product/latency; a negedge monitor pops and checks.
module tb_ppg_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        busy;

  typedef struct {
    logic [31:0] p;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  ppg_seq_mult_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
`ifdef PPG_SEQ_ZERO_SKIP_EN
    int l = 1;
    for (int i = 0; i < 16; i++)
      if (b[i]) l = i + 1;
    return l;
`else
    return 16;
`endif
  endfunction

  // called just after a posedge; returns just after the accept edge
  task automatic do_op(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic hold);
    int   n = 0;
    exp_t e;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(n), 64'(0));
      in_valid = 1'b0;
      return;
    end
    e.p   = 32'(a) * 32'(b);
    e.lat = exp_lat(b);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = hold;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    check("busy_after_accept", 64'(busy), 64'(1));
    check("in_ready_after_accept", 64'(in_ready), 64'(0));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  // monitor: latency, product, hold under backpressure, ready after handshake
  initial begin
    logic        ov_prev = 1'b0;
    logic        or_prev = 1'b0;
    logic [31:0] p_prev = '0;
    logic        rdy_chk = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
        or_prev = 1'b0;
        rdy_chk = 1'b0;
      end else begin
        if (rdy_chk) begin
          check("in_ready_after_hs", 64'(in_ready), 64'(1));
          rdy_chk = 1'b0;
        end
        if (out_valid && !ov_prev) begin
          if (exp_q.size() == 0)
            check("unexpected_out", 64'(out_p), 64'hDEAD);
          else
            check("latency", 64'(cyc - exp_q[0].acc),
                  64'(exp_q[0].lat));
        end
        if (out_valid && ov_prev && !or_prev)
          check("hold_out_p", 64'(out_p), 64'(p_prev));
        if (out_valid)
          check("in_ready_in_done", 64'(in_ready), 64'(0));
        if (out_valid && out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("product", 64'(out_p), 64'(e.p));
          rdy_chk = 1'b1;
        end
        ov_prev = out_valid;
        or_prev = out_ready;
        p_prev  = out_p;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_p", 64'(out_p), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    do_op(16'h0003, 16'h0005, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0);
    do_op(16'h1234, 16'h0000, 1'b0);
    do_op(16'h0000, 16'h1234, 1'b0);
    drain();

    out_ready = 1'b0;
    do_op(16'h00FF, 16'h0100, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_out_valid", 64'(out_valid), 64'(1));
    repeat (10) @(posedge clk);
    #1;
    check("bp_out_p", 64'(out_p), 64'h0000FF00);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    do_op(16'hABCD, 16'h0001, 1'b0);
    do_op(16'h0007, 16'h0010, 1'b0);
    do_op(16'h1357, 16'h8000, 1'b0);
    drain();

    do_op(16'h1234, 16'h5678, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_out_p", 64'(out_p), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op(16'h0002, 16'h0003, 1'b0);
    drain();

    for (int i = 0; i < 1000; i++)
      do_op(16'($urandom),
            16'($urandom) >> $urandom_range(0, 16), 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ppg_seq_mult_ctrl.md
Name: ppg_seq_mult_ctrl

Overview:
Sequential shift-add multiplier controller that time-shares a single 16-bit partial-product generator (PPG row: a AND b_bit) across all multiplier bits. It accepts an operand pair over a valid/ready handshake and feeds one multiplier bit per cycle into the PPG. It accumulates the shifted partial products into a 32-bit exact product and returns the result over a second valid/ready handshake. It serves as the exact reference and recovery path beside the approximate multiplier arrays.

Parameters:
- WIDTH, 16, operand width. Must equal the PPG row width; only 16 is legal (elaboration-time check).
- CNT_W, 4, bit-index counter width. Equals clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- in_a  input  16  multiplicand (unsigned)
- in_b  input  16  multiplier (unsigned)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out_p  output  32  product in_a*in_b (unsigned)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_p=0, busy=0, accumulator=0, bit index=0, operand registers=0. Reset asserted mid-RUN or mid-DONE aborts the operation; the result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a_r=in_a and b_r=in_b, clear acc, set idx=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the PPG is driven with (a_r, b_r[idx]); acc <= acc + (zero-extended pp << idx), computed at 32-bit width with no overflow.
  - idx increments each cycle. The edge that processes idx=15 loads out_p with the final acc and moves to DONE.
  - Latency: out_valid rises exactly 16 cycles after the accept edge.
- DONE:
  - out_valid=1; out_p is held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE, out_valid=0. out_p keeps its last value.
- No overlap: the next accept happens no earlier than the cycle after the output handshake. Throughput is one operation per 18 cycles with out_ready tied high.
- in_valid while not in IDLE is ignored. in_a and in_b are don't-care outside the accept cycle.
- out_ready while not in DONE is ignored.
- Boundaries:
  - a=0 or b=0 gives p=0.
  - 0xFFFF*0xFFFF = 0xFFFE0001.
  - Accumulator is 32 bits and cannot wrap.
  - idx wraps 15->0 only on entering DONE.

Optional Feature:
- Macro: PPG_SEQ_ZERO_SKIP_EN.
- Defined: early termination in RUN. After processing bit idx, if b_r[15:idx+1]==0 (all higher bits zero, or idx=15), load out_p and go to DONE on that edge.
  - Latency = (index of highest set bit of in_b)+1, minimum 1.
  - b=0 or b=1 gives latency 1; b=0x8000 gives latency 16.
  - Product is unchanged (exact).
- Undefined: fixed 16-cycle latency as above.

Decomposition:
- Package ppg_mult_pkg holds:
  - localparam PPG_W=16, PROD_W=32, IDX_W=4;
  - typedef enum logic [1:0] {IDLE, RUN, DONE} ppg_state_t;
  - typedef logic [PPG_W-1:0] operand_t; typedef logic [PROD_W-1:0] product_t.
- Sub-module: one instance of the team's existing PPG row (module PPG, ports res/a/b), driven by a_r and b_r[idx].
- Shift-add, counter and FSM stay in this block; no further sub-modules.

Test Plan:
- Reset then in_a=0x0003, in_b=0x0005, out_ready=1 -> out_valid exactly 16 cycles after accept; out_p=0x0000000F; in_ready high the cycle after the output handshake.
- in_a=0xFFFF, in_b=0xFFFF -> out_p=0xFFFE0001. Also in_a=0x1234, in_b=0 -> out_p=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid with in_valid held high, in_a=0x00FF, in_b=0x0100 -> out_p=0x0000FF00 held stable; in_ready=0 throughout; no second accept until after the handshake.
- Assert rst for 1 cycle at RUN cycle 7 -> out_valid=0, out_p=0, in_ready=1 immediately (asynchronous); the next op in_a=2, in_b=3 gives out_p=6.
- With PPG_SEQ_ZERO_SKIP_EN defined: in_b=0x0001 -> latency 1, p=in_a; in_b=0x0010, in_a=7 -> latency 5, p=0x70; in_b=0x8000 -> latency 16. Random 1000 pairs compared against a*b in both builds.
